seven_segment_display_driver: RTL

SEVEN_SEGMENT_DISPLAY_DRIVER -- requirements
Module: seven_segment_display_driver

---
 rtl/seven_segment_display_driver.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/seven_segment_display_driver.sv
// Seven-segment display driver.
// Captures an unsigned value on I_LOAD and renders it on NUM_DIGITS seven-segment digits,
// either as hexadecimal or as decimal. Decimal values are converted by a sequential
// double-dabble, one bit per cycle. Optional leading-zero blanking. A value that does not
// fit on the digits shows a dash on every digit.
//
// Ports:
//   I_CLK       clock, rising edge
//   I_NRESET    asynchronous active-low reset
//   I_DATA      value to display (DATA_WIDTH bits, unsigned)
//   I_LOAD      capture request for I_DATA/I_MODE/I_BLANK, ignored while busy
//   I_MODE      0 = hexadecimal, 1 = decimal
//   I_BLANK     1 = blank leading zero digits
//   O_SEGMENTS  digit k at [7k+6:7k], abcdefg with a as MSB; inverted when ACTIVE_LOW
//   O_BUSY      high from the capture edge until the update edge
//   O_DONE      one-cycle pulse after O_SEGMENTS is updated
module seven_segment_display_driver #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                    I_CLK,
  input  logic                    I_NRESET,
  input  logic [DATA_WIDTH-1:0]   I_DATA,
  input  logic                    I_LOAD,
  input  logic                    I_MODE,
  input  logic                    I_BLANK,
  output logic [7*NUM_DIGITS-1:0] O_SEGMENTS,
  output logic                    O_BUSY,
  output logic                    O_DONE
);

  localparam int unsigned BcdW = 4 * NUM_DIGITS;
  localparam int unsigned ExtW = (DATA_WIDTH > BcdW) ? DATA_WIDTH : BcdW;
  localparam int unsigned CntW = $clog2(DATA_WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

  localparam logic [6:0] SegDash  = 7'h01;
  localparam logic [6:0] SegBlank = 7'h00;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StUpdate
  } state_e;

  state_e                  r_state;
  state_e                  w_state_next;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_mode;
  logic                    r_blank;
  logic [BcdW-1:0]         r_bcd;
  logic                    r_ovf;
  logic [CntW-1:0]         r_cnt;
  logic [7*NUM_DIGITS-1:0] r_segments;
  logic                    r_busy;
  logic                    r_done;

  logic [BcdW-1:0]         w_bcd_adj;
  logic [BcdW-1:0]         w_bcd_shifted;
  logic [ExtW-1:0]         w_data_ext;
  logic                    w_hex_ovf;
  logic                    w_ovf;
  logic [BcdW-1:0]         w_digits;
  logic [7*NUM_DIGITS-1:0] w_seg_next;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h7E;
      4'h1: s = 7'h30;
      4'h2: s = 7'h6D;
      4'h3: s = 7'h79;
      4'h4: s = 7'h33;
      4'h5: s = 7'h5B;
      4'h6: s = 7'h5F;
      4'h7: s = 7'h70;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h7B;
      4'hA: s = 7'h77;
      4'hB: s = 7'h1F;
      4'hC: s = 7'h0D;
      4'hD: s = 7'h3D;
      4'hE: s = 7'h4F;
      4'hF: s = 7'h47;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (I_LOAD) begin
          w_state_next = I_MODE ? StShift : StUpdate;
        end
      end
      StShift: begin
        if (r_cnt == LastCnt) begin
          w_state_next = StUpdate;
        end
      end
      StUpdate: w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Double-dabble step: add 3 to every nibble >= 5, then shift in the next data MSB
  // ---------------------------------------------------------------------------
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) begin
        w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
      end
    end
  end

  assign w_bcd_shifted = {w_bcd_adj[BcdW-2:0], r_data[DATA_WIDTH-1]};

  // ---------------------------------------------------------------------------
  // Digit selection and segment rendering
  // ---------------------------------------------------------------------------
  // Zero-extension covers digits beyond DATA_WIDTH; bits above the digits flag hex overflow.
  assign w_data_ext = ExtW'(r_data);
  assign w_hex_ovf  = |(w_data_ext >> BcdW);
  assign w_ovf      = r_mode ? r_ovf : w_hex_ovf;
  assign w_digits   = r_mode ? r_bcd : w_data_ext[BcdW-1:0];

  always_comb begin
    logic       seen_nonzero;
    logic [3:0] nib;
    logic [6:0] seg;
    w_seg_next   = '0;
    seen_nonzero = 1'b0;
    nib          = 4'h0;
    seg          = SegBlank;
    // Walk from the top digit down so blanking stops at the first nonzero digit.
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      nib = w_digits[4*k +: 4];
      if (nib != 4'h0) begin
        seen_nonzero = 1'b1;
      end
      if (w_ovf) begin
        seg = SegDash;
      end else if (r_blank && !seen_nonzero && (k != 0)) begin
        seg = SegBlank;
      end else begin
        seg = hex_to_seg(nib);
      end
      w_seg_next[7*k +: 7] = seg;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      r_data     <= '0;
      r_mode     <= 1'b0;
      r_blank    <= 1'b0;
      r_bcd      <= '0;
      r_ovf      <= 1'b0;
      r_cnt      <= '0;
      r_segments <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (I_LOAD) begin
            r_data  <= I_DATA;
            r_mode  <= I_MODE;
            r_blank <= I_BLANK;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        StShift: begin
          r_bcd  <= w_bcd_shifted;
          // Anything leaving the top nibble means the value needs more digits than we have.
          r_ovf  <= r_ovf | w_bcd_adj[BcdW-1];
          r_data <= {r_data[DATA_WIDTH-2:0], 1'b0};
          r_cnt  <= r_cnt + 1'b1;
        end
        StUpdate: begin
          r_segments <= w_seg_next;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Segments are kept active-high internally; polarity is applied only at the pins.
  assign O_SEGMENTS = r_segments ^ {(7 * NUM_DIGITS){ACTIVE_LOW}};
  assign O_BUSY     = r_busy;
  assign O_DONE     = r_done;

endmodule
